// File: rtl/wb_irq_sched_if.sv
// Wishbone classic slave bundle for the interrupt scheduler register port.
// Signal names follow the Wishbone _i/_o view from the slave side.
interface wb_irq_sched_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wb_irq_sched.sv
// Priority interrupt scheduler: lowest-index enabled request wins, software claims it
// through CLAIM and retires it through COMPLETE, which pulses the source's ack.
module wb_irq_sched #(
    parameter int NSRC = 4
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    wb_irq_sched_if.slave   wb,
    input  logic [NSRC-1:0] src_irq_i,
    output logic [NSRC-1:0] src_ack_o,
    output logic            cpu_irq_o
);
    typedef enum logic [1:0] {S_IDLE, S_NOTIFY, S_SERVICE, S_ACK} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [3:0]      cur_id_q, cur_id_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic [31:0]     dat_q, dat_d;

    logic [NSRC-1:0] pend;
    logic [3:0]      win_id;
    logic [1:0]      adr;
    logic            acc, claim_ok, complete_ok;
    logic            unused_bits;

    assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0], wb.wb_dat_i};

    assign pend = src_irq_i & enable_q;
    assign adr  = wb.wb_adr_i[3:2];
    // Registered termination: a held strobe is blocked for the cycle its ack/err shows.
    assign acc  = wb.wb_stb_i & wb.wb_cyc_i & ~(ack_q | err_q);

    always_comb begin
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (pend[i]) win_id = 4'(i + 1);
        end
    end

    assign claim_ok    = acc & ~wb.wb_we_i & (adr == 2'd2) & (state_q == S_NOTIFY) & (win_id != 4'd0);
    assign complete_ok = acc & wb.wb_we_i & (adr == 2'd3) & (state_q == S_SERVICE) &
                         (wb.wb_dat_i[3:0] == cur_id_q);

    always_comb begin
        state_d  = state_q;
        enable_d = enable_q;
        cur_id_d = cur_id_q;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        dat_d    = '0;

        if (acc) begin
            ack_d = 1'b1;
            case (adr)
                2'd0: if (!wb.wb_we_i) dat_d = 32'(pend);
                2'd1: begin
                    if (wb.wb_we_i) enable_d = wb.wb_dat_i[NSRC-1:0];
                    else            dat_d    = 32'(enable_q);
                end
                2'd2: if (!wb.wb_we_i && state_q == S_NOTIFY) dat_d = 32'(win_id);
                default: begin
                    if (wb.wb_we_i && !complete_ok) begin
                        ack_d = 1'b0;
                        err_d = 1'b1;
                    end
                end
            endcase
        end

        case (state_q)
            S_IDLE:    if (pend != '0) state_d = S_NOTIFY;
            S_NOTIFY: begin
                if (claim_ok) begin
                    state_d  = S_SERVICE;
                    cur_id_d = win_id;
                end else if (pend == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_SERVICE: if (complete_ok) state_d = S_ACK;
            default: begin
                state_d  = S_IDLE;
                cur_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            enable_q <= '0;
            cur_id_q <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable_d;
            cur_id_q <= cur_id_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            dat_q    <= dat_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            src_ack_o[i] = (state_q == S_ACK) && (cur_id_q == 4'(i + 1));
        end
    end

    assign cpu_irq_o   = (state_q == S_NOTIFY);
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_rty_o = 1'b0;
endmodule
